// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state type and its
// encoding, default parameters, and a small index-width helper.
package uart_tx_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 1024;

  localparam logic [1:0] ENC_IDLE      = 2'b00;
  localparam logic [1:0] ENC_SEND      = 2'b01;
  localparam logic [1:0] ENC_WAIT_BUSY = 2'b10;
  localparam logic [1:0] ENC_WAIT_DONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = ENC_IDLE,
    ST_SEND      = ENC_SEND,
    ST_WAIT_BUSY = ENC_WAIT_BUSY,
    ST_WAIT_DONE = ENC_WAIT_DONE
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin winner selection: searches ptr+1, ptr+2, ... modulo NUM_REQ and
// reports the first asserted request.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  int w_base;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_base = int'(ptr);
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (j == ((w_base + k) % NUM_REQ))) begin
          valid  = 1'b1;
          winner = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte sources, with a stall timeout and a completed-packet counter.
//
// Handshake: requester i raises req[i] with data/last stable and keeps them
// stable until it sees ack[i] high for one cycle; the byte is taken on the
// edge that raises ack, and the requester may present its next byte (or drop
// req) in the same cycle ack is visible. Only the granted owner is ever acked.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  input  logic [NUM_REQ-1:0]   last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 abort,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [15:0]          pkt_count,
  output logic [1:0]           o_dbg_state
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int SW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
  logic [IW-1:0]        r_owner, w_owner_nxt;
  logic [IW-1:0]        r_ptr, w_ptr_nxt;
  logic                 r_last_q, w_last_q_nxt;
  logic                 r_abort, w_abort_nxt;
  logic                 r_tx_start, w_tx_start_nxt;
  logic [7:0]           r_tx_data, w_tx_data_nxt;
  logic [SW-1:0]        r_stall, w_stall_nxt;
  logic [15:0]          r_pkt_count, w_pkt_count_nxt;
  logic                 w_pkt_inc;

  logic                 w_rr_valid;
  logic [IW-1:0]        w_rr_winner;
  logic                 w_owner_req;
  logic                 w_owner_last;
  logic [7:0]           w_owner_data;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_select (
    .req    (req),
    .ptr    (r_ptr),
    .valid  (w_rr_valid),
    .winner (w_rr_winner)
  );

  // Pick out the current owner's request lane.
  always_comb begin
    w_owner_req  = 1'b0;
    w_owner_last = 1'b0;
    w_owner_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_owner_req  = req[i];
        w_owner_last = last[i];
        w_owner_data = data[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_last_q_nxt   = r_last_q;
    w_tx_data_nxt  = r_tx_data;
    w_stall_nxt    = r_stall;
    w_ack_nxt      = '0;
    w_abort_nxt    = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_pkt_inc      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A frame left over from before reset must finish before granting.
        if (w_rr_valid && !tx_busy) begin
          w_owner_nxt = w_rr_winner;
          w_gnt_nxt   = NUM_REQ'(1) << w_rr_winner;
          w_stall_nxt = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_owner_req) begin
          if (!tx_busy) begin
            w_tx_start_nxt = 1'b1;
            w_tx_data_nxt  = w_owner_data;
            w_ack_nxt      = NUM_REQ'(1) << r_owner;
            w_last_q_nxt   = w_owner_last;
            w_stall_nxt    = '0;
            w_state_nxt    = ST_WAIT_BUSY;
          end
        end else if (r_stall == STALL_MAX) begin
          // Owner went quiet mid-packet for TIMEOUT cycles: reclaim the line.
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_owner;
          w_abort_nxt = 1'b1;
          w_stall_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall_nxt = r_stall + SW'(1);
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_last_q) begin
            w_ptr_nxt   = r_owner;
            w_gnt_nxt   = '0;
            w_pkt_inc   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_SEND;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pkt_count_nxt = r_pkt_count + 16'(w_pkt_inc);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered grant, handshake, transmitter drive and bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_ack      <= '0;
      r_owner    <= '0;
      r_ptr      <= IW'(NUM_REQ - 1);
      r_last_q   <= 1'b0;
      r_abort    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_stall    <= '0;
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_ack      <= w_ack_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_last_q   <= w_last_q_nxt;
      r_abort    <= w_abort_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_stall    <= w_stall_nxt;
    end
  end

  // Completed-packet counter; written every cycle and wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) r_pkt_count <= 16'h0000;
    else        r_pkt_count <= w_pkt_count_nxt;
  end

  assign ack         = r_ack;
  assign gnt         = r_gnt;
  assign abort       = r_abort;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign pkt_count   = r_pkt_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte sources per requester, a UART transmitter
// model, an expected-byte scoreboard and per-cycle protocol checks.
module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int TMO     = 16;
  localparam int BIT_CYC = 2;
  localparam int W       = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [8*NR-1:0]   data;
  logic [NR-1:0]     last;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     gnt;
  logic              abort;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [15:0]       pkt_count;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {owner[2:0], byte[7:0]} in the order bytes must start.
  logic [W-1:0] exp_q[$];
  int           exp_pkt = 0;

  // Requester byte sources: {last, data}.
  logic [8:0] src_mem [NR][8];
  int         src_len [NR];
  int         src_pos [NR];

  int gap = 100;
  int abort_cnt = 0;
  int abort_gap = 0;
  int ack_cnt [NR];
  int tx_cnt = 0;

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data        (data),
    .last        (last),
    .ack         (ack),
    .gnt         (gnt),
    .abort       (abort),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .pkt_count   (pkt_count),
    .o_dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Transmitter model: busy rises one cycle after start, lasts 11 bit-times.
  always @(posedge clk) begin
    if (tx_start && tx_cnt == 0) tx_cnt <= 11 * BIT_CYC;
    else if (tx_cnt != 0)        tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = (tx_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input int i, input logic [7:0] d, input logic l);
    src_mem[i][src_len[i]] = {l, d};
    src_len[i] = src_len[i] + 1;
  endtask

  task automatic exp_push(input int owner, input logic [7:0] d);
    exp_q.push_back({3'(owner), d});
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      ack_cnt[i] = 0;
    end
  endtask

  function automatic bit all_consumed();
    for (int i = 0; i < NR; i++)
      if (src_pos[i] < src_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      ok = all_consumed() && (exp_q.size() == 0) && (gnt == '0) && !tx_busy;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Driver: present each requester's next byte, advance on ack.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) src_pos[i] = src_pos[i] + 1;
        if (src_pos[i] < src_len[i]) begin
          req[i]         = 1'b1;
          data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
          last[i]        = src_mem[i][src_pos[i]][8];
        end else begin
          req[i]  = 1'b0;
          last[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare: protocol rules and byte order against the scoreboard.
  always @(negedge clk) begin
    int own;
    logic [W-1:0] e;
    if (tx_busy) gap = 0;
    else if (gap < 100000) gap = gap + 1;
    if (rst_n) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("ack_within_gnt", 32'(ack & ~gnt), 32'd0);
      check("ack_with_start", 32'(|ack), 32'(tx_start));
      if (abort) begin
        abort_cnt = abort_cnt + 1;
        abort_gap = gap;
        check("abort_gnt_clear", 32'(gnt), 32'd0);
      end
      if (tx_start) begin
        own = -1;
        for (int i = 0; i < NR; i++) begin
          if (ack[i]) begin
            own = i;
            ack_cnt[i] = ack_cnt[i] + 1;
          end
        end
        check("start_tx_idle", 32'(tx_busy), 32'd0);
        check("start_gap_ge2", 32'(gap >= 3), 32'd1);
        if (exp_q.size() == 0) begin
          check("byte_expected", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("byte_data", 32'(tx_data), 32'(e[7:0]));
          check("byte_owner", 32'(own), 32'(e[10:8]));
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    bit seen;
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    last  = '0;
    clear_sources();
    tick();
    tick();

    // Reset values.
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);

    // Single two-byte packet from requester 0.
    add_byte(0, 8'h41, 1'b0);
    add_byte(0, 8'h42, 1'b1);
    exp_push(0, 8'h41);
    exp_push(0, 8'h42);
    exp_pkt = 1;
    rst_n = 1'b1;
    wait_done("t1_single_done", 400);
    check("t1_tx_data_held", 32'(tx_data), 32'h42);
    check("t1_ack0_pulses", 32'(ack_cnt[0]), 32'd2);
    check("t1_pkt_count", 32'(pkt_count), 32'd1);
    check("t1_gnt_idle", 32'(gnt), 32'd0);

    // Contention from reset release: order 0,1,2,3 then 0 again.
    rst_n = 1'b0;
    clear_sources();
    for (int i = 0; i < NR; i++) add_byte(i, 8'hA0 + 8'(i), 1'b1);
    add_byte(0, 8'hA4, 1'b1);
    exp_push(0, 8'hA0);
    exp_push(1, 8'hA1);
    exp_push(2, 8'hA2);
    exp_push(3, 8'hA3);
    exp_push(0, 8'hA4);
    exp_pkt = 5;
    tick();
    tick();
    rst_n = 1'b1;
    wait_done("t2_contention_done", 800);
    check("t2_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    check("t2_pkt_count_lit", 32'(pkt_count), 32'd5);

    // No interleave: requester 1 three-byte packet while requester 2 waits.
    clear_sources();
    add_byte(1, 8'h10, 1'b0);
    add_byte(1, 8'h11, 1'b0);
    add_byte(1, 8'h12, 1'b1);
    add_byte(2, 8'h20, 1'b1);
    exp_push(1, 8'h10);
    exp_push(1, 8'h11);
    exp_push(1, 8'h12);
    exp_push(2, 8'h20);
    exp_pkt = exp_pkt + 2;
    wait_done("t3_no_interleave_done", 800);
    check("t3_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Stall: requester 3 sends one non-last byte then goes quiet.
    clear_sources();
    abort_cnt = 0;
    add_byte(3, 8'h30, 1'b0);
    add_byte(0, 8'h50, 1'b1);
    exp_push(3, 8'h30);
    exp_push(0, 8'h50);
    exp_pkt = exp_pkt + 1;
    wait_done("t4_stall_done", 800);
    check("t4_abort_once", 32'(abort_cnt), 32'd1);
    check("t4_abort_timing", 32'(abort_gap), 32'(TMO + 2));
    check("t4_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Reset while the transmitter is mid-frame.
    clear_sources();
    add_byte(1, 8'h60, 1'b0);
    add_byte(1, 8'h61, 1'b1);
    exp_push(1, 8'h60);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      seen = tx_busy;
    end
    check("t5_busy_seen", 32'(seen), 32'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    clear_sources();
    tick();
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_ack", 32'(ack), 32'd0);
    check("t5_rst_tx_start", 32'(tx_start), 32'd0);
    check("t5_rst_tx_data", 32'(tx_data), 32'd0);
    check("t5_rst_abort", 32'(abort), 32'd0);
    check("t5_rst_pkt_count", 32'(pkt_count), 32'd0);
    tick();
    add_byte(2, 8'h70, 1'b1);
    exp_push(2, 8'h70);
    exp_pkt = 1;
    rst_n = 1'b1;
    tick();
    check("t5_no_grant_while_busy", 32'(gnt), 32'd0);
    wait_done("t5_after_reset_done", 400);
    check("t5_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Counter wrap from a preloaded 0xFFFF.
    clear_sources();
    force dut.r_pkt_count = 16'hFFFF;
    tick();
    tick();
    release dut.r_pkt_count;
    tick();
    exp_pkt = 16'hFFFF;
    check("t6_preload", 32'(pkt_count), 32'(exp_pkt));
    add_byte(3, 8'h7E, 1'b1);
    exp_push(3, 8'h7E);
    exp_pkt = (exp_pkt + 1) % 65536;
    wait_done("t6_wrap_done", 400);
    check("t6_wrap", 32'(pkt_count), 32'(exp_pkt));
    check("t6_wrap_lit", 32'(pkt_count), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 1024, clock cycles an owner may stall mid-packet before forced release.
REQ-003 Port clk  in  1  single clock; all logic on posedge clk.
REQ-004 Port rst_n  in  1  synchronous reset, active-low.
REQ-005 Port req  in  NUM_REQ  per-requester byte valid.
REQ-006 Port data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 Port last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req.
REQ-008 Port ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
REQ-009 Port gnt  out  NUM_REQ  one-hot current packet owner; all zero when idle.
REQ-010 Port abort  out  1  one-cycle pulse on timeout release.
REQ-011 Port tx_start  out  1  to transmitter start input.
REQ-012 Port tx_data  out  8  to transmitter data input.
REQ-013 Port tx_busy  in  1  from transmitter busy output.
REQ-014 Port pkt_count  out  16  completed packets, wraps 0xFFFF->0.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: when any req=1 and tx_busy=0, winner = first set req searching ptr+1, ptr+2, ... modulo NUM_REQ; gnt<=onehot(winner); -> SEND.
REQ-017 Arbitration is per packet: gnt SHALL stay constant from grant until last byte completes or timeout.
REQ-018 SEND with req[owner]=1 and tx_busy=0: register tx_start<=1, tx_data<=data[owner], ack[owner]<=1, last_q<=last[owner], clear stall counter; -> WAIT_BUSY.
REQ-019 tx_start and ack SHALL be high exactly one cycle per byte; tx_data held until next accepted byte.
REQ-020 Requester holds data/last stable while req=1 until ack; may present next byte the cycle ack is seen.
REQ-021 Non-owner req SHALL be ignored and never acked.
REQ-022 WAIT_BUSY: stay until tx_busy=1 (one cycle after tx_start), -> WAIT_DONE.
REQ-023 WAIT_DONE: on tx_busy=0, if last_q=1: ptr<=owner, gnt<=0, pkt_count+=1, -> IDLE; else -> SEND.
REQ-024 SEND with req[owner]=0: stall counter increments; at TIMEOUT-1 -> IDLE, gnt<=0, ptr<=owner, abort pulses, pkt_count unchanged.
REQ-025 Byte-to-byte gap: next tx_start no earlier than 2 cycles after tx_busy falls.
REQ-026 Simultaneous requests in IDLE resolved solely by REQ-016; single requester with back-to-back packets is re-granted immediately if alone.
REQ-027 Stall counter width = clog2(TIMEOUT); SEND never starts a byte while tx_busy=1.

Reset
REQ-028 rst_n=0 at posedge clk: state IDLE, gnt=0, ack=0, abort=0, tx_start=0, tx_data=0x00, pkt_count=0, ptr=NUM_REQ-1, stall counter=0.
REQ-029 Reset mid-byte: transmitter has no reset and completes its frame; after release IDLE SHALL not grant until tx_busy=0.

Structure
REQ-030 Shared package holds FSM state enum, state encoding constants, default NUM_REQ/TIMEOUT.
REQ-031 Round-robin winner selection SHALL be sub-module rr_select (inputs req, ptr; outputs valid, winner index).
REQ-032 Transmitter is instantiated outside; this block connects only via tx_start/tx_data/tx_busy.

Verification (bench uses a transmitter model: busy rises 1 cycle after start, stays 11 bit-times)
REQ-033 Single packet: req0 sends 0x41,0x42(last) -> tx_data 0x41 then 0x42, two ack[0] pulses, pkt_count=1, gnt returns 0.
REQ-034 Contention: req0..3 all assert 1-byte packets at reset release -> grant order 0,1,2,3, then 0 again if re-asserted.
REQ-035 No interleave: req1 holds 3-byte packet while req2 requests -> all 3 req1 bytes sent before any req2 byte.
REQ-036 Stall: owner drops req after byte 1 for TIMEOUT=16 cycles -> abort pulses once, gnt=0, pkt_count unchanged, next requester granted.
REQ-037 Reset with tx_busy=1 -> all outputs reset values; no tx_start until tx_busy=0.
REQ-038 Wrap: preload 0xFFFF completed packets via force, one more packet -> pkt_count=0x0000.
